fetch_sequencer: RTL and testbench

//  Instruction-fetch controller for the RV32 core front end.
//  - Sequences the PC and issues requests on a req/gnt/rvalid instruction-memory port.
//  - Buffers returned words in an in-order FIFO.
//  - Presents {pc, instr, opcode} to fetch_decode/ImmGen over a valid/ready handshake.
//  - Handles redirects (branch/jump/trap) by flushing buffered and in-flight words.

---
 rtl/fetch_sequencer_if.sv | 35 +++
 rtl/fetch_sequencer.sv | 128 ++++++++++++
 tb/tb_fetch_sequencer.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: imem req/gnt/rvalid port, redirect input and
// decode valid/ready handshake of the RV32 fetch sequencer.
interface fetch_sequencer_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic [4:0]  dec_opcode;
  logic        fetch_fault;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata,
    input  redirect_valid, redirect_pc,
    output dec_valid, dec_instr, dec_pc, dec_opcode,
    input  dec_ready,
    output fetch_fault
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata,
    output redirect_valid, redirect_pc,
    input  dec_valid, dec_instr, dec_pc, dec_opcode,
    output dec_ready,
    input  fetch_fault
  );
endinterface

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: PC sequencing, in-order instruction buffer, redirect flush.
// Optional FETCH_MISALIGN_EN: misaligned redirect parks fetch in HALT.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input logic clk,
  input logic reset_n,
  fetch_sequencer_if.master bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH = (CW+1)'(FIFO_DEPTH);

  localparam logic [1:0] BOOT  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;
`ifdef FETCH_MISALIGN_EN
  localparam logic [1:0] HALT  = 2'd3;
`endif

  logic [1:0]    state;
  logic [31:0]   addr_q, target_q, resp_pc_q;
  logic [CW-1:0] count_q, outst_q, drop_q, outst_n;
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic          req_hold;
  logic [31:0]   pc_buf  [FIFO_DEPTH];
  logic [31:0]   ins_buf [FIFO_DEPTH];

  logic          req, gnt_fire, rv_ok, redir;
  logic          flushing, hold_n, exit_flush;
  logic          push, pop;
  logic [1:0]    resume_state;
  logic [31:0]   tgt_sel;
  logic [CW:0]   inflight;

  assign inflight = {1'b0, outst_q} + {1'b0, count_q};
  assign req      = req_hold | ((state == RUN) && (inflight < DEPTH));
  assign gnt_fire = req & bus.imem_gnt;
  assign rv_ok    = bus.imem_rvalid & (outst_q != '0);
  assign outst_n  = outst_q + CW'(gnt_fire) - CW'(rv_ok);
  assign redir    = bus.redirect_valid;
  assign flushing = redir | (state == FLUSH);
  // a request left ungranted must stay up, even across a redirect
  assign hold_n     = req & ~bus.imem_gnt;
  assign exit_flush = flushing && (outst_n == '0) && !hold_n;
  assign push = rv_ok & ~redir & (drop_q == '0) & (state == RUN);
  assign pop  = bus.dec_valid & bus.dec_ready;
  assign tgt_sel = redir ? (bus.redirect_pc & 32'hFFFF_FFFC) : target_q;

`ifdef FETCH_MISALIGN_EN
  logic halt_q;
  logic halt_sel;

  assign halt_sel = redir ? (bus.redirect_pc[1:0] != 2'b00) : halt_q;
  assign resume_state = halt_sel ? HALT : RUN;
  assign bus.fetch_fault = (state == HALT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      halt_q <= 1'b0;
    end else if (redir) begin
      halt_q <= halt_sel;
    end
  end
`else
  assign resume_state = RUN;
  assign bus.fetch_fault = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= BOOT;
      addr_q    <= RESET_PC;
      target_q  <= RESET_PC;
      resp_pc_q <= RESET_PC;
      outst_q   <= '0;
      drop_q    <= '0;
      req_hold  <= 1'b0;
    end else begin
      outst_q  <= outst_n;
      drop_q   <= flushing ? outst_n : '0;
      req_hold <= hold_n;
      if (redir) target_q <= tgt_sel;
      if (exit_flush) begin
        addr_q    <= tgt_sel;
        resp_pc_q <= tgt_sel;
        state     <= resume_state;
      end else begin
        if (flushing) state <= FLUSH;
        else if (state == BOOT) state <= RUN;
        if (gnt_fire) addr_q <= addr_q + 32'd4;
        if (rv_ok) resp_pc_q <= resp_pc_q + 32'd4;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        pc_buf[i]  <= '0;
        ins_buf[i] <= '0;
      end
    end else if (redir) begin
      count_q <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
    end else begin
      if (push) begin
        pc_buf[wr_ptr]  <= resp_pc_q;
        ins_buf[wr_ptr] <= bus.imem_rdata;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  assign bus.imem_req   = req;
  assign bus.imem_addr  = addr_q;
  assign bus.dec_valid  = (count_q != '0);
  assign bus.dec_instr  = ins_buf[rd_ptr];
  assign bus.dec_pc     = pc_buf[rd_ptr];
  assign bus.dec_opcode = ins_buf[rd_ptr][6:2];
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed steps, imem model with in-order latency,
// scoreboard of expected decode words.
module tb_fetch_sequencer;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int DEPTH = 2;

  typedef struct {
    logic [31:0] addr;
    bit          drop;
    int          due;
  } fl_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int lat = 1;
  fl_t iq[$];
  logic [31:0] sb[$];
  logic [31:0] exp_addr = RST_PC;
  logic [31:0] tgt = RST_PC;
  logic [31:0] held_addr = '0;
  logic [31:0] stall_pc = '0;
  logic [31:0] last_gnt = '0;
  logic [31:0] pend;
  bit redir_pend = 0;
  bit held = 0;
  bit stalled = 0;
  bit wrap_seen = 0;

  always #5 clk = ~clk;

  fetch_sequencer_if bus ();

  fetch_sequencer #(
    .RESET_PC(RST_PC),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h0) ? 32'h0a018613 : (a ^ 32'h5A5A_0013);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_dec(input string tag);
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (bus.dec_valid) return;
    end
    total++;
    bad++;
    $error("FAIL %s timeout waiting for dec_valid", tag);
  endtask

  // memory: in-order responses, lat cycles after grant
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (reset_n && iq.size() != 0 && iq[0].due <= cyc) begin
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = mem_word(iq[0].addr);
    end else begin
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = 32'hDEAD_BEEF;
    end
  end

  always @(negedge clk) begin
    fl_t f;
    logic [31:0] e;
    logic [31:0] w;
    if (!reset_n) begin
      iq.delete();
      sb.delete();
      exp_addr   = RST_PC;
      redir_pend = 0;
      held       = 0;
      stalled    = 0;
    end else begin
      chk("dec_valid", bus.dec_valid, sb.size() != 0);
      if (held) begin
        chk("req_held", bus.imem_req, 1);
        chk("addr_held", bus.imem_addr, held_addr);
      end
      if (stalled) chk("stall_pc", bus.dec_pc, stall_pc);
      if (bus.dec_valid && bus.dec_ready && sb.size() != 0) begin
        e = sb.pop_front();
        w = mem_word(e);
        chk("dec_pc", bus.dec_pc, e);
        chk("dec_instr", bus.dec_instr, w);
        chk("dec_opcode", bus.dec_opcode, w[6:2]);
      end
      if (bus.imem_rvalid && iq.size() != 0) begin
        f = iq.pop_front();
        if (!f.drop && !bus.redirect_valid) sb.push_back(f.addr);
      end
      if (bus.imem_req && bus.imem_gnt) begin
        if (redir_pend && !held) begin
          exp_addr   = tgt;
          redir_pend = 0;
        end
        chk("imem_addr", bus.imem_addr, exp_addr);
        if (bus.imem_addr == 0 && last_gnt == 32'hFFFF_FFFC)
          wrap_seen = 1;
        last_gnt = bus.imem_addr;
        iq.push_back('{exp_addr, redir_pend || bus.redirect_valid,
                       cyc + lat});
        exp_addr = exp_addr + 32'd4;
      end
      if (bus.redirect_valid) begin
        foreach (iq[i]) iq[i].drop = 1'b1;
        sb.delete();
        redir_pend = 1;
        tgt = bus.redirect_pc & 32'hFFFF_FFFC;
      end
      held      = bus.imem_req && !bus.imem_gnt;
      held_addr = bus.imem_addr;
      stalled   = bus.dec_valid && !bus.dec_ready && !bus.redirect_valid;
      stall_pc  = bus.dec_pc;
    end
  end

  initial begin
    bus.imem_gnt       = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.dec_ready      = 1'b0;
    reset_n = 1'b0;
    repeat (3) step();
    chk("rst_req", bus.imem_req, 0);
    chk("rst_addr", bus.imem_addr, RST_PC);
    chk("rst_dvalid", bus.dec_valid, 0);
    chk("rst_dpc", bus.dec_pc, 0);
    chk("rst_dinstr", bus.dec_instr, 0);
    chk("rst_fault", bus.fetch_fault, 0);

    // streaming fetch from reset
    bus.imem_gnt  = 1'b1;
    bus.dec_ready = 1'b1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("boot_req", bus.imem_req, 0);
    @(negedge clk);
    chk("first_req", bus.imem_req, 1);
    chk("first_addr", bus.imem_addr, RST_PC);
    wait_dec("t1");
    chk("t1_pc", bus.dec_pc, 32'h0);
    chk("t1_instr", bus.dec_instr, 32'h0a018613);
    chk("t1_opc", bus.dec_opcode, 5'b00100);
    repeat (10) step();

    // decode stall fills the buffer, then requests stop
    bus.dec_ready = 1'b0;
    repeat (10) step();
    chk("t2_req", bus.imem_req, 0);
    chk("t2_fill", sb.size(), DEPTH);
    chk("t2_outst", iq.size(), 0);
    bus.dec_ready = 1'b1;
    repeat (10) step();

    // redirect with two words in flight
    lat = 3;
    for (int k = 0; k < 30; k++) begin
      step();
      if (iq.size() == 2) break;
    end
    chk("t3_inflight", iq.size(), 2);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h100;
    step();
    bus.redirect_valid = 1'b0;
    lat = 1;
    wait_dec("t3");
    chk("t3_pc", bus.dec_pc, 32'h100);
    repeat (6) step();

    // redirect while request waits for grant
    bus.imem_gnt = 1'b0;
    repeat (4) step();
    chk("t4_req", bus.imem_req, 1);
    pend = bus.imem_addr;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h300;
    step();
    bus.redirect_valid = 1'b0;
    step();
    step();
    chk("t4_hold", bus.imem_addr, pend);
    bus.imem_gnt = 1'b1;
    wait_dec("t4");
    chk("t4_pc", bus.dec_pc, 32'h300);
    repeat (4) step();

`ifdef FETCH_MISALIGN_EN
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h102;
    step();
    bus.redirect_valid = 1'b0;
    repeat (6) step();
    chk("t6_fault", bus.fetch_fault, 1);
    chk("t6_req", bus.imem_req, 0);
    chk("t6_dvalid", bus.dec_valid, 0);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h200;
    step();
    bus.redirect_valid = 1'b0;
    chk("t6_clear", bus.fetch_fault, 0);
    wait_dec("t6");
    chk("t6_pc", bus.dec_pc, 32'h200);
`else
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h106;
    step();
    bus.redirect_valid = 1'b0;
    wait_dec("mis");
    chk("mis_pc", bus.dec_pc, 32'h104);
    chk("mis_fault", bus.fetch_fault, 0);
`endif
    repeat (4) step();

    // address wrap, then reset mid-stream
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFF8;
    step();
    bus.redirect_valid = 1'b0;
    for (int k = 0; k < 30; k++) begin
      step();
      if (wrap_seen) break;
    end
    chk("t5_wrap", wrap_seen, 1);
    repeat (3) step();
    #1;
    reset_n = 1'b0;
    #1;
    chk("t5_req", bus.imem_req, 0);
    chk("t5_addr", bus.imem_addr, RST_PC);
    chk("t5_dvalid", bus.dec_valid, 0);
    chk("t5_dpc", bus.dec_pc, 0);
    chk("t5_dinstr", bus.dec_instr, 0);
    chk("t5_fault", bus.fetch_fault, 0);
    repeat (2) step();
    reset_n = 1'b1;
    @(negedge clk);
    chk("t5_boot", bus.imem_req, 0);
    wait_dec("t5");
    chk("t5_pc", bus.dec_pc, RST_PC);
    repeat (8) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
